mpe_sched: RTL and testbench

MPE_SCHED -- requirements
Module: mpe_sched

---
 rtl/mpe_pkg.sv | 17 +
 rtl/mpe_addr_gen.sv | 53 +++++
 rtl/mpe_sched.sv | 157 +++++++++++++++
 tb/tb_mpe_sched.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpe_pkg.sv
// Shared definitions for the matrix-PE command scheduler: sequencer states,
// default widths and the micro-op width.
package mpe_pkg;

    localparam int MPE_ADDR_W = 16;
    localparam int MPE_LEN_W  = 8;
    localparam int UOP_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UOP      = 3'd1,
        ST_STREAM   = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_DONE     = 3'd4
    } mpe_state_e;

endpackage

// File: rtl/mpe_addr_gen.sv
// Beat-address generator for one operand stream (NRAM or WRAM).
// A start pulse loads the base address and beat count; afterwards the stream
// requests until len beats have been handed off, advancing only on handshake.
module mpe_addr_gen
    import mpe_pkg::*;
#(
    parameter int ADDR_W = MPE_ADDR_W,
    parameter int LEN_W  = MPE_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic              valid,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic              finished
);

    logic             active;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic             fire;

    assign valid    = active && (cnt != len_q);
    assign fire     = valid && ready;
    assign cnt_nxt  = cnt + LEN_W'(fire);
    // Finished includes the beat handed off this cycle so the sequencer can
    // leave the streaming phase right after the last handshake.
    assign finished = active && (cnt_nxt == len_q);

    // Load on start, then step address and issued count on each handshake.
    // Address arithmetic wraps naturally at the register width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            len_q  <= '0;
            cnt    <= '0;
            addr   <= '0;
        end else if (start) begin
            active <= 1'b1;
            len_q  <= len;
            cnt    <= '0;
            addr   <= base;
        end else if (fire) begin
            cnt    <= cnt_nxt;
            addr   <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/mpe_sched.sv
// Matrix-PE command scheduler: accepts one command, forwards its micro-op,
// streams neuron and weight beat requests, then waits for the PE result.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | ready for a command (cmd_ready high)
//   ST_UOP      | offering the latched micro-op until uop_ready
//   ST_STREAM   | NRAM and WRAM request streams running independently
//   ST_WAIT_RES | both streams issued, waiting for the PE result
//   ST_DONE     | one-cycle done pulse, then back to idle
module mpe_sched
    import mpe_pkg::*;
#(
    parameter int ADDR_W = MPE_ADDR_W,
    parameter int LEN_W  = MPE_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [UOP_W-1:0]  cmd_uop,
    input  logic [ADDR_W-1:0] cmd_nbase,
    input  logic [ADDR_W-1:0] cmd_wbase,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              uop_valid,
    output logic [UOP_W-1:0]  uop,
    input  logic              uop_ready,
    output logic              nram_req_valid,
    output logic [ADDR_W-1:0] nram_req_addr,
    input  logic              nram_req_ready,
    output logic              wram_req_valid,
    output logic [ADDR_W-1:0] wram_req_addr,
    input  logic              wram_req_ready,
    input  logic              pe_vld_o,
    output logic              busy,
    output logic              done
);

    mpe_state_e        state;
    mpe_state_e        state_nxt;
    logic [UOP_W-1:0]  uop_q;
    logic [ADDR_W-1:0] nbase_q;
    logic [ADDR_W-1:0] wbase_q;
    logic [LEN_W-1:0]  len_q;
    logic              res_seen;
    logic              accept;
    logic              stream_start;
    logic              n_finished;
    logic              w_finished;

    assign accept       = cmd_valid && cmd_ready;
    assign stream_start = (state == ST_UOP) && uop_ready;
    assign uop          = uop_q;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command fields are captured on acceptance and held for the whole command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uop_q   <= '0;
            nbase_q <= '0;
            wbase_q <= '0;
            len_q   <= '0;
        end else if (accept) begin
            uop_q   <= cmd_uop;
            nbase_q <= cmd_nbase;
            wbase_q <= cmd_wbase;
            len_q   <= cmd_len;
        end
    end

    // A PE result can arrive before streaming ends; remember it so WAIT_RES
    // does not hang for a pulse that already happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_seen <= 1'b0;
        end else if (state == ST_DONE) begin
            res_seen <= 1'b0;
        end else if (pe_vld_o && ((state == ST_UOP) || (state == ST_STREAM))) begin
            res_seen <= 1'b1;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        uop_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                // Held low while reset is asserted even though state is idle.
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    state_nxt = (cmd_len != '0) ? ST_UOP : ST_DONE;
                end
            end
            ST_UOP: begin
                uop_valid = 1'b1;
                if (uop_ready) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (n_finished && w_finished) state_nxt = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (pe_vld_o || res_seen) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    mpe_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_nram_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (stream_start),
        .base     (nbase_q),
        .len      (len_q),
        .valid    (nram_req_valid),
        .ready    (nram_req_ready),
        .addr     (nram_req_addr),
        .finished (n_finished)
    );

    mpe_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_wram_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (stream_start),
        .base     (wbase_q),
        .len      (len_q),
        .valid    (wram_req_valid),
        .ready    (wram_req_ready),
        .addr     (wram_req_addr),
        .finished (w_finished)
    );

endmodule

// File: tb/tb_mpe_sched.sv
// Self-checking bench for mpe_sched. Each command is driven and observed by
// exec(); the test tasks compare observations against expectations derived
// from the command fields (address sequence base+i mod 2^16, one micro-op,
// done timing from when the result pulse and the last beat occurred).
module tb_mpe_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_uop;
    logic [15:0] cmd_nbase;
    logic [15:0] cmd_wbase;
    logic [7:0]  cmd_len;
    logic        uop_valid;
    logic [7:0]  uop;
    logic        uop_ready;
    logic        nram_req_valid;
    logic [15:0] nram_req_addr;
    logic        nram_req_ready;
    logic        wram_req_valid;
    logic [15:0] wram_req_addr;
    logic        wram_req_ready;
    logic        pe_vld_o;
    logic        busy;
    logic        done;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc = 0;

    // observations of the most recent exec()
    logic [15:0] q_n[$];
    logic [15:0] q_w[$];
    int          n_uop, uop_cyc, pe_cyc, last_n, last_w, done_cyc;
    int          stab_err, rdy_err, accept_cyc;
    bit          timeout;
    logic [7:0]  uop_obs;

    // command offered while the previous one is busy (back-to-back test)
    logic [15:0] h_nb, h_wb;
    logic [7:0]  h_ln, h_uo;

    mpe_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_uop        (cmd_uop),
        .cmd_nbase      (cmd_nbase),
        .cmd_wbase      (cmd_wbase),
        .cmd_len        (cmd_len),
        .uop_valid      (uop_valid),
        .uop            (uop),
        .uop_ready      (uop_ready),
        .nram_req_valid (nram_req_valid),
        .nram_req_addr  (nram_req_addr),
        .nram_req_ready (nram_req_ready),
        .wram_req_valid (wram_req_valid),
        .wram_req_addr  (wram_req_addr),
        .wram_req_ready (wram_req_ready),
        .pe_vld_o       (pe_vld_o),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one command and record everything until done (or abort_rel cycles
    // after acceptance). bp = percent chance each ready is low. The bench PE
    // pulses pe_vld_o pe_delay cycles after the micro-op handshake.
    task automatic exec(input logic [15:0] nb, input logic [15:0] wb,
                        input logic [7:0] ln, input logic [7:0] uo,
                        input int bp, input int pe_delay,
                        input int abort_rel, input bit hold);
        bit          pn, pw, pu;
        logic [15:0] an, aw;
        logic [7:0]  au;
        q_n.delete();
        q_w.delete();
        n_uop = 0; uop_obs = '0; uop_cyc = -1; pe_cyc = -1;
        last_n = -1; last_w = -1; done_cyc = -1;
        stab_err = 0; rdy_err = 0; accept_cyc = -1; timeout = 0;
        pn = 0; pw = 0; pu = 0; an = '0; aw = '0; au = '0;
        @(negedge clk);
        cmd_nbase = nb; cmd_wbase = wb; cmd_len = ln; cmd_uop = uo;
        cmd_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (cmd_ready) begin
                accept_cyc = cyc;
                break;
            end
        end
        if (accept_cyc < 0) begin
            timeout = 1;
            cmd_valid = 1'b0;
            return;
        end
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (hold) begin
                cmd_valid = 1'b1;
                cmd_nbase = h_nb; cmd_wbase = h_wb; cmd_len = h_ln; cmd_uop = h_uo;
            end else begin
                cmd_valid = 1'b0;
            end
            nram_req_ready = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
            wram_req_ready = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
            uop_ready      = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
            pe_vld_o = 1'b0;
            if (cyc - accept_cyc == abort_rel) return;
            #1;
            if (cmd_ready) rdy_err++;
            if (pn && (!nram_req_valid || nram_req_addr !== an)) stab_err++;
            if (pw && (!wram_req_valid || wram_req_addr !== aw)) stab_err++;
            if (pu && (!uop_valid || uop !== au)) stab_err++;
            pn = nram_req_valid && !nram_req_ready; an = nram_req_addr;
            pw = wram_req_valid && !wram_req_ready; aw = wram_req_addr;
            pu = uop_valid && !uop_ready;           au = uop;
            if (nram_req_valid && nram_req_ready) begin
                q_n.push_back(nram_req_addr);
                last_n = cyc;
            end
            if (wram_req_valid && wram_req_ready) begin
                q_w.push_back(wram_req_addr);
                last_w = cyc;
            end
            if (uop_valid && uop_ready) begin
                n_uop++;
                uop_obs = uop;
                uop_cyc = cyc;
            end
            if (uop_cyc >= 0 && cyc == uop_cyc + pe_delay) begin
                pe_vld_o = 1'b1;
                pe_cyc = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) timeout = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks_total++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready);
        else checks_passed++;
        checks_total++;
        if ({uop_valid, nram_req_valid, wram_req_valid, busy, done} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {uop_valid, nram_req_valid, wram_req_valid, busy, done});
        else checks_passed++;
        checks_total++;
        if ({uop, nram_req_addr, wram_req_addr} !== 40'h0)
            $display("FAIL reset_values got=%h exp=0", {uop, nram_req_addr, wram_req_addr});
        else checks_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks_total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release_idle got_ready=%b got_busy=%b exp=1/0", cmd_ready, busy);
        else checks_passed++;
    endtask

    task automatic test_basic();
        int t, errs, r, last, exp_done;
        exec(16'h0010, 16'h0100, 8'd4, 8'hA5, 0, 2, -1, 0);
        t = accept_cyc;
        r = t + 1 + 2;
        last = t + 1 + 4;
        exp_done = (r <= last) ? last + 2 : r + 1;
        checks_total++;
        if (timeout) $display("FAIL basic_timeout got=1 exp=0");
        else checks_passed++;
        checks_total++;
        if (n_uop !== 1 || uop_obs !== 8'hA5)
            $display("FAIL basic_uop got_count=%0d got_uop=%h exp=1/a5", n_uop, uop_obs);
        else checks_passed++;
        checks_total++;
        if (uop_cyc !== t + 1) $display("FAIL basic_uop_latency got=%0d exp=%0d", uop_cyc - t, 1);
        else checks_passed++;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= q_n.size() || q_n[i] !== 16'(16'h0010 + i)) errs++;
            if (i >= q_w.size() || q_w[i] !== 16'(16'h0100 + i)) errs++;
        end
        checks_total++;
        if (errs != 0 || q_n.size() != 4 || q_w.size() != 4)
            $display("FAIL basic_addrs got_n=%0d got_w=%0d bad=%0d exp=4/4/0", q_n.size(), q_w.size(), errs);
        else checks_passed++;
        checks_total++;
        if (last_n !== last || last_w !== last)
            $display("FAIL basic_last_req got=%0d/%0d exp=%0d", last_n - t, last_w - t, last - t);
        else checks_passed++;
        checks_total++;
        if (done_cyc !== exp_done) $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc - t, exp_done - t);
        else checks_passed++;
        @(negedge clk);
        #1;
        checks_total++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL basic_after_done got_done=%b busy=%b ready=%b exp=0/0/1", done, busy, cmd_ready);
        else checks_passed++;
    endtask

    task automatic test_wrap();
        logic [15:0] exp_n[4];
        int errs;
        exp_n[0] = 16'hFFFE; exp_n[1] = 16'hFFFF; exp_n[2] = 16'h0000; exp_n[3] = 16'h0001;
        exec(16'hFFFE, 16'hFFFD, 8'd4, 8'h5A, 0, 1, -1, 0);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= q_n.size() || q_n[i] !== exp_n[i]) errs++;
            if (i >= q_w.size() || q_w[i] !== 16'(16'hFFFD + i)) errs++;
        end
        checks_total++;
        if (timeout || errs != 0 || q_n.size() != 4 || q_w.size() != 4)
            $display("FAIL wrap_addrs got_n=%0d got_w=%0d bad=%0d timeout=%0d exp=4/4/0/0",
                     q_n.size(), q_w.size(), errs, timeout);
        else checks_passed++;
    endtask

    task automatic test_early_result_and_len0();
        int t;
        exec(16'h0300, 16'h0700, 8'd6, 8'h42, 0, 2, -1, 0);
        t = accept_cyc;
        checks_total++;
        if (timeout || done_cyc !== t + 3 + 6)
            $display("FAIL early_res_done got=%0d exp=%0d timeout=%0d", done_cyc - t, 9, timeout);
        else checks_passed++;
        exec(16'h1234, 16'h4321, 8'd0, 8'h99, 0, 0, -1, 0);
        t = accept_cyc;
        checks_total++;
        if (timeout || done_cyc !== t + 1)
            $display("FAIL len0_done got=%0d exp=1 timeout=%0d", done_cyc - t, timeout);
        else checks_passed++;
        checks_total++;
        if (n_uop !== 0 || q_n.size() != 0 || q_w.size() != 0)
            $display("FAIL len0_no_traffic got_uop=%0d got_n=%0d got_w=%0d exp=0/0/0", n_uop, q_n.size(), q_w.size());
        else checks_passed++;
    endtask

    task automatic test_idle_pe_ignored();
        int t;
        @(negedge clk);
        pe_vld_o = 1'b1;
        @(negedge clk);
        pe_vld_o = 1'b0;
        exec(16'h0020, 16'h0040, 8'd2, 8'h01, 0, 10, -1, 0);
        t = accept_cyc;
        checks_total++;
        if (timeout || done_cyc !== t + 1 + 10 + 1)
            $display("FAIL idle_pe_ignored got=%0d exp=%0d timeout=%0d", done_cyc - t, 12, timeout);
        else checks_passed++;
    endtask

    task automatic test_backpressure();
        logic [15:0] nb, wb;
        logic [7:0]  ln;
        int errs, last, exp_done, pd;
        for (int c = 0; c < 7; c++) begin
            nb = 16'($urandom);
            wb = 16'($urandom);
            ln = (c == 0) ? 8'd140 : ((c == 3) ? 8'd0 : 8'($urandom_range(40, 1)));
            pd = $urandom_range(60);
            exec(nb, wb, ln, 8'($urandom), 50, pd, -1, 0);
            errs = 0;
            for (int i = 0; i < int'(ln); i++) begin
                if (i >= q_n.size() || q_n[i] !== 16'(nb + i)) errs++;
                if (i >= q_w.size() || q_w[i] !== 16'(wb + i)) errs++;
            end
            checks_total++;
            if (timeout || errs != 0 || q_n.size() != int'(ln) || q_w.size() != int'(ln))
                $display("FAIL bp_beats cmd=%0d got_n=%0d got_w=%0d bad=%0d exp=%0d timeout=%0d",
                         c, q_n.size(), q_w.size(), errs, ln, timeout);
            else checks_passed++;
            checks_total++;
            if (stab_err != 0) $display("FAIL bp_stable cmd=%0d got_violations=%0d exp=0", c, stab_err);
            else checks_passed++;
            checks_total++;
            if (n_uop !== ((ln == 0) ? 0 : 1))
                $display("FAIL bp_uop_count cmd=%0d got=%0d exp=%0d", c, n_uop, (ln == 0) ? 0 : 1);
            else checks_passed++;
            if (ln == 0) begin
                exp_done = accept_cyc + 1;
            end else begin
                last = (last_n > last_w) ? last_n : last_w;
                exp_done = (pe_cyc >= 0 && pe_cyc <= last) ? last + 2 : pe_cyc + 1;
            end
            checks_total++;
            if (done_cyc !== exp_done) $display("FAIL bp_done cmd=%0d got=%0d exp=%0d", c, done_cyc, exp_done);
            else checks_passed++;
            @(negedge clk);
            #1;
            checks_total++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL bp_single_done cmd=%0d got_done=%b got_busy=%b exp=0/0", c, done, busy);
            else checks_passed++;
        end
        nram_req_ready = 1'b1;
        wram_req_ready = 1'b1;
        uop_ready = 1'b1;
    endtask

    task automatic test_reset_mid_stream();
        int errs, t;
        exec(16'h0200, 16'h0300, 8'd8, 8'h77, 0, 1000, 4, 0);
        checks_total++;
        if (timeout || q_n.size() != 2)
            $display("FAIL rstmid_beats_before got=%0d exp=2 timeout=%0d", q_n.size(), timeout);
        else checks_passed++;
        rst_n = 1'b0;
        pe_vld_o = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checks_total++;
        if ({nram_req_valid, wram_req_valid, uop_valid, busy, done} !== 5'b0)
            $display("FAIL rstmid_outputs got=%b exp=00000", {nram_req_valid, wram_req_valid, uop_valid, busy, done});
        else checks_passed++;
        errs = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done) errs++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (done) errs++;
        checks_total++;
        if (errs != 0) $display("FAIL rstmid_no_done got_pulses=%0d exp=0", errs);
        else checks_passed++;
        exec(16'h0400, 16'h0500, 8'd3, 8'h12, 0, 1, -1, 0);
        t = accept_cyc;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (i >= q_n.size() || q_n[i] !== 16'(16'h0400 + i)) errs++;
            if (i >= q_w.size() || q_w[i] !== 16'(16'h0500 + i)) errs++;
        end
        checks_total++;
        if (timeout || errs != 0 || q_n.size() != 3 || q_w.size() != 3 || done_cyc !== t + 6)
            $display("FAIL rstmid_next_cmd got_n=%0d got_w=%0d bad=%0d done=%0d exp=3/3/0/6",
                     q_n.size(), q_w.size(), errs, done_cyc - t);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        int d1, r1, errs;
        h_nb = 16'h0A00; h_wb = 16'h0B00; h_ln = 8'd3; h_uo = 8'h3C;
        exec(16'h0500, 16'h0600, 8'd5, 8'h11, 0, 1, -1, 1);
        d1 = done_cyc;
        r1 = rdy_err;
        checks_total++;
        if (timeout || r1 != 0) $display("FAIL b2b_ready_while_busy got=%0d exp=0 timeout=%0d", r1, timeout);
        else checks_passed++;
        exec(h_nb, h_wb, h_ln, h_uo, 0, 1, -1, 0);
        checks_total++;
        if (accept_cyc !== d1 + 1) $display("FAIL b2b_accept_cycle got=%0d exp=%0d", accept_cyc - d1, 1);
        else checks_passed++;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (i >= q_n.size() || q_n[i] !== 16'(16'h0A00 + i)) errs++;
            if (i >= q_w.size() || q_w[i] !== 16'(16'h0B00 + i)) errs++;
        end
        checks_total++;
        if (timeout || errs != 0 || uop_obs !== 8'h3C || q_n.size() != 3)
            $display("FAIL b2b_second_cmd got_uop=%h bad=%0d got_n=%0d exp=3c/0/3", uop_obs, errs, q_n.size());
        else checks_passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_uop = '0;
        cmd_nbase = '0;
        cmd_wbase = '0;
        cmd_len = '0;
        uop_ready = 1'b1;
        nram_req_ready = 1'b1;
        wram_req_ready = 1'b1;
        pe_vld_o = 1'b0;
        h_nb = '0; h_wb = '0; h_ln = '0; h_uo = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_early_result_and_len0();
        test_idle_pe_ignored();
        test_backpressure();
        test_reset_mid_stream();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
